regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arb_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 25 ++
 rtl/regfile_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and default sizes for the register-file arbiter
//
// Purpose : state encoding of the arbiter FSM and default address/data widths.
// Contents: DEFAULT_AW, DEFAULT_DW, state_t {IDLE, ISSUE, CAPTURE, RESP}.
package regfile_arb_pkg;

    localparam int unsigned DEFAULT_AW = 4;
    localparam int unsigned DEFAULT_DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way arbiter with last-served pointer input
//
// Purpose : picks one of two requests. On a tie the requester that was not
//           last served wins; a constant pointer of 1 gives req0 priority.
// Ports   : i_req[1:0]   request vector
//           i_last       index of the requester served most recently
//           o_grant[1:0] one-hot grant, 2'b00 when nothing requests
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_req[0] && i_req[1]) begin
            o_grant = i_last ? 2'b01 : 2'b10;
        end else if (i_req[0]) begin
            o_grant = 2'b01;
        end else if (i_req[1]) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester arbiter in front of a single-port register file
//
// Purpose : serialises accesses from two requesters onto one register file
//           whose read data arrives one cycle after the address.
//           Write: IDLE -> ISSUE -> IDLE. Read: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
// Macro   : REGFILE_ARB_ROUND_ROBIN_EN - defined: round-robin on ties using a
//           last-served pointer; undefined: fixed priority, req0 wins.
// Ports   : clock, reset_n (async, active low)
//           reqN_valid/write/addr/wdata  request from requester N (N=0,1)
//           reqN_ready                   accept strobe (with reqN_valid)
//           reqN_rvalid/rdata            read response, rdata held between responses
//           rf_address/rf_en_write/rf_data_in/rf_data_out  register-file port
//           busy                         high whenever not IDLE
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned AW = DEFAULT_AW,
    parameter int unsigned DW = DEFAULT_DW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req0_valid,
    input  logic          req0_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          req0_rvalid,
    output logic [DW-1:0] req0_rdata,
    input  logic          req1_valid,
    input  logic          req1_write,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          req1_rvalid,
    output logic [DW-1:0] req1_rdata,
    output logic [AW-1:0] rf_address,
    output logic          rf_en_write,
    output logic [DW-1:0] rf_data_in,
    input  logic [DW-1:0] rf_data_out,
    output logic          busy
);

    state_t        r_state;
    state_t        w_next_state;
    logic [1:0]    w_grant;
    logic          w_last;
    logic          w_accept;
    logic          r_gnt;
    logic          r_write;
    logic [AW-1:0] r_rf_address;
    logic [DW-1:0] r_rf_data_in;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    rr_arbiter2 u_arb (
        .i_req   ({req1_valid, req0_valid}),
        .i_last  (w_last),
        .o_grant (w_grant)
    );

    // Grant is only honoured in IDLE; any valid requester yields a grant bit.
    assign w_accept = (r_state == IDLE) && (w_grant != 2'b00);

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    logic r_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_grant[1];
        end
    end

    assign w_last = r_last;
`else
    // Pretending requester 1 was always served last makes req0 win every tie.
    assign w_last = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = ISSUE;
            ISSUE:   w_next_state = r_write ? IDLE : CAPTURE;
            CAPTURE: w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt        <= 1'b0;
            r_write      <= 1'b0;
            r_rf_address <= '0;
            r_rf_data_in <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            if (w_accept) begin
                r_gnt        <= w_grant[1];
                r_write      <= w_grant[1] ? req1_write : req0_write;
                r_rf_address <= w_grant[1] ? req1_addr  : req0_addr;
                r_rf_data_in <= w_grant[1] ? req1_wdata : req0_wdata;
            end
            // The register file presents data for the ISSUE-cycle address here.
            if (r_state == CAPTURE) begin
                if (r_gnt) begin
                    r_rdata1 <= rf_data_out;
                end else begin
                    r_rdata0 <= rf_data_out;
                end
            end
        end
    end

    always_comb begin
        req0_ready  = (r_state == IDLE) && w_grant[0];
        req1_ready  = (r_state == IDLE) && w_grant[1];
        req0_rvalid = (r_state == RESP) && !r_gnt;
        req1_rvalid = (r_state == RESP) && r_gnt;
        rf_en_write = (r_state == ISSUE) && r_write;
        busy        = (r_state != IDLE);
    end

    assign rf_address = r_rf_address;
    assign rf_data_in = r_rf_data_in;
    assign req0_rdata = r_rdata0;
    assign req1_rdata = r_rdata1;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - self-checking bench for regfile_arbiter
module tb_regfile_arbiter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid, req0_write, req0_ready, req0_rvalid;
    logic [3:0] req0_addr;
    logic [7:0] req0_wdata, req0_rdata;
    logic       req1_valid, req1_write, req1_ready, req1_rvalid;
    logic [3:0] req1_addr;
    logic [7:0] req1_wdata, req1_rdata;
    logic [3:0] rf_address;
    logic       rf_en_write;
    logic [7:0] rf_data_in;
    logic [7:0] rf_data_out;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Requests waiting to be accepted (held until accept).
    bit         p_valid [2];
    bit         p_write [2];
    logic [3:0] p_addr  [2];
    logic [7:0] p_wdata [2];

    // Reference model state.
    logic [7:0] mem_model [16];
    logic [7:0] exp_rdata [2];
    int         last_served;

    logic [7:0] rf_mem [16];

    always #5 clock = ~clock;

    regfile_arbiter #(.AW(4), .DW(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_write  (req0_write),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_ready  (req0_ready),
        .req0_rvalid (req0_rvalid),
        .req0_rdata  (req0_rdata),
        .req1_valid  (req1_valid),
        .req1_write  (req1_write),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_ready  (req1_ready),
        .req1_rvalid (req1_rvalid),
        .req1_rdata  (req1_rdata),
        .rf_address  (rf_address),
        .rf_en_write (rf_en_write),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out),
        .busy        (busy)
    );

    // Register file with one-cycle registered read.
    always @(posedge clock) begin
        if (rf_en_write) rf_mem[rf_address] <= rf_data_in;
        rf_data_out <= rf_mem[rf_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic port_ready(input int n);
        return (n == 1) ? req1_ready : req0_ready;
    endfunction

    function automatic logic port_rvalid(input int n);
        return (n == 1) ? req1_rvalid : req0_rvalid;
    endfunction

    function automatic logic [7:0] port_rdata(input int n);
        return (n == 1) ? req1_rdata : req0_rdata;
    endfunction

    // Tie: round-robin serves whoever was not last served; fixed priority serves req0.
    function automatic int model_winner();
        if (p_valid[0] && p_valid[1]) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            return (last_served == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return p_valid[0] ? 0 : 1;
    endfunction

    task automatic drive_inputs();
        req0_valid = p_valid[0];
        req0_write = p_write[0];
        req0_addr  = p_addr[0];
        req0_wdata = p_wdata[0];
        req1_valid = p_valid[1];
        req1_write = p_write[1];
        req1_addr  = p_addr[1];
        req1_wdata = p_wdata[1];
    endtask

    task automatic post(input int n, input bit wr, input logic [3:0] a, input logic [7:0] d);
        p_valid[n] = 1'b1;
        p_write[n] = wr;
        p_addr[n]  = a;
        p_wdata[n] = d;
    endtask

    // Called and returns at the drive point (1 time unit after a rising edge) in IDLE.
    task automatic transact();
        int w;
        int o;
        w = model_winner();
        o = 1 - w;
        drive_inputs();
        @(negedge clock);
        check("idle_busy", busy, 1'b0);
        check("idle_rvalid0", req0_rvalid, 1'b0);
        check("idle_rvalid1", req1_rvalid, 1'b0);
        check("ready_winner", port_ready(w), 1'b1);
        check("ready_loser", port_ready(o), 1'b0);
        @(posedge clock); #1;
        p_valid[w] = 1'b0;
        last_served = w;
        drive_inputs();
        @(negedge clock);
        check("issue_busy", busy, 1'b1);
        check("issue_wen", rf_en_write, p_write[w]);
        check("issue_addr", rf_address, p_addr[w]);
        if (p_write[w]) check("issue_wdata", rf_data_in, p_wdata[w]);
        check("issue_ready0", req0_ready, 1'b0);
        check("issue_ready1", req1_ready, 1'b0);
        if (p_write[w]) begin
            mem_model[p_addr[w]] = p_wdata[w];
            @(posedge clock); #1;
        end else begin
            @(posedge clock); #1;
            @(negedge clock);
            check("capt_wen", rf_en_write, 1'b0);
            check("capt_rvalid", port_rvalid(w), 1'b0);
            check("capt_ready_loser", port_ready(o), 1'b0);
            @(posedge clock); #1;
            @(negedge clock);
            exp_rdata[w] = mem_model[p_addr[w]];
            check("resp_rvalid", port_rvalid(w), 1'b1);
            check("resp_rvalid_loser", port_rvalid(o), 1'b0);
            check("resp_rdata", port_rdata(w), exp_rdata[w]);
            check("resp_rdata_loser_held", port_rdata(o), exp_rdata[o]);
            check("resp_ready_loser", port_ready(o), 1'b0);
            check("resp_wen", rf_en_write, 1'b0);
            @(posedge clock); #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_wen"}, rf_en_write, 1'b0);
        check({tag, "_addr"}, rf_address, 4'h0);
        check({tag, "_wdata"}, rf_data_in, 8'h00);
        check({tag, "_rdata0"}, req0_rdata, 8'h00);
        check({tag, "_rdata1"}, req1_rdata, 8'h00);
        check({tag, "_rvalid0"}, req0_rvalid, 1'b0);
        check({tag, "_rvalid1"}, req1_rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            p_valid[i] = 1'b0; p_write[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
            exp_rdata[i] = 8'h00;
        end
        last_served = 1;
        drive_inputs();

        // Reset state
        #12;
        check_reset_state("reset");
        @(posedge clock); #1;
        reset_n = 1'b1;

        // No requests: stays idle, nothing ready
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("noreq_ready0", req0_ready, 1'b0);
            check("noreq_ready1", req1_ready, 1'b0);
            check("noreq_busy", busy, 1'b0);
            @(posedge clock); #1;
        end

        // Write 3 <- A5 then read 3 from req0
        post(0, 1'b1, 4'd3, 8'hA5);
        transact();
        post(0, 1'b0, 4'd3, 8'h00);
        transact();
        check("wr_rd_a5", req0_rdata, 8'hA5);

        // All 16 addresses written back-to-back from req1, read back from req0
        for (int i = 0; i < 16; i++) begin
            post(1, 1'b1, 4'(i), 8'(8'h10 + i));
            transact();
        end
        for (int i = 0; i < 16; i++) begin
            post(0, 1'b0, 4'(i), 8'h00);
            transact();
            check("sweep_rdata", req0_rdata, 8'(8'h10 + i));
        end

        // Simultaneous reads, with req0 re-requesting while req1 still waits
        post(0, 1'b0, 4'd2, 8'h00);
        post(1, 1'b0, 4'd7, 8'h00);
        transact();
        post(0, 1'b0, 4'd9, 8'h00);
        transact();
        transact();

        // req0 kept busy while req1 waits
        post(1, 1'b1, 4'd12, 8'hC3);
        for (int i = 0; i < 4; i++) begin
            post(0, 1'b1, 4'(i), 8'($urandom_range(0, 255)));
            transact();
        end
        while (p_valid[0] || p_valid[1]) transact();

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (!p_valid[n] && ($urandom_range(0, 1) == 1))
                    post(n, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            end
            if (!p_valid[0] && !p_valid[1])
                post($urandom_range(0, 1), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            transact();
        end
        while (p_valid[0] || p_valid[1]) transact();

        // Reset during CAPTURE of a read to address 5
        post(0, 1'b1, 4'd5, 8'h5C);
        transact();
        post(0, 1'b0, 4'd5, 8'h00);
        drive_inputs();
        @(posedge clock); #1;
        p_valid[0] = 1'b0;
        drive_inputs();
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("midreset");
        last_served = 1;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        @(negedge clock);
        check("midreset_hold_rvalid0", req0_rvalid, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("postreset_rvalid0", req0_rvalid, 1'b0);
            check("postreset_rvalid1", req1_rvalid, 1'b0);
            check("postreset_busy", busy, 1'b0);
            check("postreset_wen", rf_en_write, 1'b0);
            @(posedge clock); #1;
        end

        // Pointer returns to its reset value: a tie goes to req0 first
        post(0, 1'b1, 4'd1, 8'h3E);
        post(1, 1'b1, 4'd14, 8'h71);
        transact();
        transact();
        post(1, 1'b0, 4'd14, 8'h00);
        transact();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
